// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// MD_LATENCY_DEFAULT is also the MULT/DIV unit's occupancy of EX.
package pipeline_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN,
        MD_WAIT,
        FLUSH,
        HALT
    } seq_state_t;

    localparam int unsigned MD_LATENCY_DEFAULT = 4;
    localparam int unsigned PERF_W_DEFAULT     = 16;
    // Wide enough for MD_LATENCY up to 15.
    localparam int unsigned MD_CNT_W           = 4;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Request/control bundle between the sequencer and the pipeline datapath.
// Master is the sequencer; slave is the pipeline side.
interface pipeline_sequencer_if
    import pipeline_sequencer_pkg::*;
#(
    parameter int unsigned PERF_W = PERF_W_DEFAULT
) ();

    logic              load_use_stall;
    logic              branch_taken;
    logic              md_issue;
    logic              halt_req;

    logic              pc_en;
    logic              s1_en;
    logic              s2_en;
    logic              s1_flush;
    logic              s2_bubble;
    logic              s3_bubble;
    logic              md_start;
    logic              md_done;
    logic              halted;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        input  load_use_stall, branch_taken, md_issue, halt_req,
        output pc_en, s1_en, s2_en, s1_flush, s2_bubble, s3_bubble,
               md_start, md_done, halted, stall_cycles
    );

    modport slave (
        output load_use_stall, branch_taken, md_issue, halt_req,
        input  pc_en, s1_en, s2_en, s1_flush, s2_bubble, s3_bubble,
               md_start, md_done, halted, stall_cycles
    );

endinterface

// File: rtl/pipeline_sequencer_sat_counter.sv
// Width-parameterised saturating incrementer with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush sequencer for the 4-stage pipeline: load-use stalls,
// taken-branch flush, multi-cycle MULT/DIV occupancy of EX, and HALT.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int unsigned PERF_W     = PERF_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_sequencer_if.master  seq
);

    localparam logic [MD_CNT_W-1:0] MD_RELOAD =
        (MD_LATENCY >= 2) ? MD_CNT_W'(MD_LATENCY - 2) : '0;

    seq_state_t          state;
    seq_state_t          state_nxt;
    logic [MD_CNT_W-1:0] md_cnt;
    logic [MD_CNT_W-1:0] md_cnt_nxt;

    logic pc_en;
    logic s1_en;
    logic s2_en;
    logic s1_flush;
    logic s2_bubble;
    logic s3_bubble;
    logic md_start;
    logic md_done;
    logic halted;
    logic stall_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        pc_en      = 1'b0;
        s1_en      = 1'b0;
        s2_en      = 1'b0;
        s1_flush   = 1'b0;
        s2_bubble  = 1'b0;
        s3_bubble  = 1'b0;
        md_start   = 1'b0;
        md_done    = 1'b0;
        halted     = 1'b0;

        if (rst_n) begin
            unique case (state)
                RUN: begin
                    pc_en = 1'b1;
                    s1_en = 1'b1;
                    s2_en = 1'b1;
                    if (seq.halt_req) begin
                        pc_en     = 1'b0;
                        s1_en     = 1'b0;
                        s2_en     = 1'b0;
                        s2_bubble = 1'b1;
                        state_nxt = HALT;
                    end else if (seq.md_issue) begin
                        md_start = 1'b1;
                        // A single-cycle op finishes in its issue cycle; no freeze.
                        if (MD_LATENCY == 1) begin
                            md_done = 1'b1;
                        end else begin
                            md_cnt_nxt = MD_RELOAD;
                            state_nxt  = MD_WAIT;
                        end
                    end else if (seq.load_use_stall) begin
                        pc_en     = 1'b0;
                        s1_en     = 1'b0;
                        s2_bubble = 1'b1;
                    end else if (seq.branch_taken) begin
                        s1_flush  = 1'b1;
                        state_nxt = FLUSH;
                    end
                end

                MD_WAIT: begin
                    s3_bubble = 1'b1;
                    if (md_cnt == '0) begin
                        md_done   = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        md_cnt_nxt = md_cnt - 1'b1;
                    end
                end

                // ID holds the squashed NOP, so every request is ignored here.
                FLUSH: begin
                    pc_en     = 1'b1;
                    s1_en     = 1'b1;
                    s2_en     = 1'b1;
                    state_nxt = RUN;
                end

                HALT: begin
                    halted = 1'b1;
                end

                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign stall_inc = rst_n && !pc_en && (state != HALT);

    sat_counter #(
        .W (PERF_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (stall_inc),
        .count (seq.stall_cycles)
    );

    assign seq.pc_en     = pc_en;
    assign seq.s1_en     = s1_en;
    assign seq.s2_en     = s2_en;
    assign seq.s1_flush  = s1_flush;
    assign seq.s2_bubble = s2_bubble;
    assign seq.s3_bubble = s3_bubble;
    assign seq.md_start  = md_start;
    assign seq.md_done   = md_done;
    assign seq.halted    = halted;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: table-driven main sequence
// plus hand-written MD_LATENCY=1 and PERF_W=4 saturation sequences.
module tb_pipeline_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic lus, br, md, hlt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    pipeline_sequencer_if #(.PERF_W(16)) bus    ();
    pipeline_sequencer_if #(.PERF_W(16)) bus_l1 ();
    pipeline_sequencer_if #(.PERF_W(4))  bus_p4 ();

    assign bus.load_use_stall    = lus;
    assign bus.branch_taken      = br;
    assign bus.md_issue          = md;
    assign bus.halt_req          = hlt;
    assign bus_l1.load_use_stall = lus;
    assign bus_l1.branch_taken   = br;
    assign bus_l1.md_issue       = md;
    assign bus_l1.halt_req       = hlt;
    assign bus_p4.load_use_stall = lus;
    assign bus_p4.branch_taken   = br;
    assign bus_p4.md_issue       = md;
    assign bus_p4.halt_req       = hlt;

    pipeline_sequencer #(.MD_LATENCY(4), .PERF_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .seq   (bus)
    );

    pipeline_sequencer #(.MD_LATENCY(1), .PERF_W(16)) dut_l1 (
        .clk   (clk),
        .rst_n (rst_n),
        .seq   (bus_l1)
    );

    pipeline_sequencer #(.MD_LATENCY(4), .PERF_W(4)) dut_p4 (
        .clk   (clk),
        .rst_n (rst_n),
        .seq   (bus_p4)
    );

    // ctrl = {pc_en,s1_en,s2_en,s1_flush,s2_bubble,s3_bubble,md_start,md_done,halted}
    typedef struct {
        logic        rst;
        logic        lus;
        logic        br;
        logic        md;
        logic        hlt;
        logic [8:0]  ctrl;
        int unsigned cnt;
    } vec_t;

    typedef struct {
        int          row;
        logic [8:0]  ctrl;
        int unsigned cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    function automatic logic [8:0] ctrl_of(input logic [8:0] dummy_sel, input int which);
        logic [8:0] v;
        v = dummy_sel;
        case (which)
            0: v = {bus.pc_en, bus.s1_en, bus.s2_en, bus.s1_flush, bus.s2_bubble,
                    bus.s3_bubble, bus.md_start, bus.md_done, bus.halted};
            1: v = {bus_l1.pc_en, bus_l1.s1_en, bus_l1.s2_en, bus_l1.s1_flush, bus_l1.s2_bubble,
                    bus_l1.s3_bubble, bus_l1.md_start, bus_l1.md_done, bus_l1.halted};
            default: v = {bus_p4.pc_en, bus_p4.s1_en, bus_p4.s2_en, bus_p4.s1_flush, bus_p4.s2_bubble,
                          bus_p4.s3_bubble, bus_p4.md_start, bus_p4.md_done, bus_p4.halted};
        endcase
        return v;
    endfunction

    task automatic add(input logic r, input logic l, input logic b, input logic m,
                       input logic h, input logic [8:0] c, input int unsigned n);
        vec_t v;
        v.rst = r; v.lus = l; v.br = b; v.md = m; v.hlt = h; v.ctrl = c; v.cnt = n;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic l, input logic b, input logic m, input logic h);
        @(posedge clk);
        #1;
        rst_n = r; lus = l; br = b; md = m; hlt = h;
    endtask

    task automatic chk_ctrl(input string name, input logic [8:0] got, input logic [8:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic chk_cnt(input string name, input int unsigned got, input int unsigned want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; lus = 1'b0; br = 1'b0; md = 1'b0; hlt = 1'b0;
        repeat (2) @(posedge clk);

        //   rst lus br md hlt  ctrl           cnt
        add(0, 0, 0, 0, 0, 9'b000_000_000, 0);  // in reset: all zero
        add(1, 0, 0, 0, 0, 9'b111_000_000, 0);
        add(1, 0, 0, 0, 0, 9'b111_000_000, 0);
        add(1, 0, 0, 0, 0, 9'b111_000_000, 0);
        add(1, 0, 0, 0, 0, 9'b111_000_000, 0);
        add(1, 0, 0, 0, 0, 9'b111_000_000, 0);
        add(1, 1, 0, 0, 0, 9'b001_010_000, 0);  // load-use bubble
        add(1, 0, 0, 0, 0, 9'b111_000_000, 1);
        add(1, 0, 0, 1, 0, 9'b111_000_100, 1);  // md_start at T
        add(1, 0, 0, 0, 0, 9'b000_001_000, 1);  // T+1 freeze
        add(1, 1, 1, 0, 0, 9'b000_001_000, 2);  // T+2 requests ignored
        add(1, 0, 0, 0, 0, 9'b000_001_010, 3);  // T+3 md_done
        add(1, 0, 0, 0, 0, 9'b111_000_000, 4);  // T+4 RUN
        add(1, 0, 1, 0, 0, 9'b111_100_000, 4);  // branch flush
        add(1, 1, 1, 0, 0, 9'b111_000_000, 4);  // FLUSH masks both
        add(1, 0, 0, 0, 0, 9'b111_000_000, 4);
        add(1, 1, 1, 0, 0, 9'b001_010_000, 4);  // load-use beats branch
        add(1, 0, 0, 0, 0, 9'b111_000_000, 5);
        add(1, 1, 0, 1, 1, 9'b000_010_000, 5);  // halt wins
        add(1, 0, 0, 0, 0, 9'b000_000_001, 6);
        add(1, 1, 1, 1, 0, 9'b000_000_001, 6);  // halted, counter frozen
        add(0, 0, 0, 0, 0, 9'b000_000_000, 6);  // reset out of HALT
        add(1, 0, 0, 0, 0, 9'b111_000_000, 0);
        add(1, 0, 0, 1, 0, 9'b111_000_100, 0);
        add(0, 0, 0, 0, 0, 9'b000_000_000, 0);  // reset mid MD_WAIT
        add(1, 0, 0, 0, 0, 9'b111_000_000, 0);  // no md_done after reset
        add(1, 1, 0, 0, 0, 9'b001_010_000, 0);
        add(1, 1, 0, 0, 0, 9'b001_010_000, 1);  // back-to-back bubbles
        add(1, 0, 0, 0, 0, 9'b111_000_000, 2);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].lus, tbl[i].br, tbl[i].md, tbl[i].hlt);
            e.row = i; e.ctrl = tbl[i].ctrl; e.cnt = tbl[i].cnt;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            chk_ctrl($sformatf("ctrl row %0d", e.row), ctrl_of('0, 0), e.ctrl);
            chk_cnt($sformatf("stall_cycles row %0d", e.row), 32'(bus.stall_cycles), e.cnt);
        end

        // MD_LATENCY=1: start and done together, no freeze
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        @(negedge clk);
        chk_ctrl("l1 issue", ctrl_of('0, 1), 9'b111_000_110);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk_ctrl("l1 after", ctrl_of('0, 1), 9'b111_000_000);
        chk_cnt("l1 stall_cycles", 32'(bus_l1.stall_cycles), 0);

        // PERF_W=4 saturation with 20 load-use stalls
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 0, 0);
            if (i == 15) begin
                @(negedge clk);
                chk_cnt("p4 reach 15", 32'(bus_p4.stall_cycles), 15);
            end
        end
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk_cnt("p4 saturated", 32'(bus_p4.stall_cycles), 15);
        chk_cnt("main count 20", 32'(bus.stall_cycles), 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
